inst_fetch: RTL

Instruction fetch unit feeding the 6502 prime decoder. After reset it loads the PC from the reset vector. It then reads the opcode plus 0–2 operand bytes from an 8-bit memory port and presents one complete instruction to the decoder over a valid/ready handshake. Execute redirects it with a PC load for branches and jumps.

---
 rtl/inst_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - 6502 instruction fetch unit: reset vector load, opcode/operand fetch, decoder handshake
module inst_fetch #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [7:0]  inst_opcode,
  output logic [7:0]  inst_op1,
  output logic [7:0]  inst_op2,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc,
  input  logic        pc_load,
  input  logic [15:0] pc_load_addr
);

  typedef enum logic [2:0] {VEC_LO, VEC_HI, OPC, OP1, OP2, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [7:0]  inst_opcode_q, inst_opcode_d;
  logic [7:0]  inst_op1_q, inst_op1_d;
  logic [7:0]  inst_op2_q, inst_op2_d;
  logic [1:0]  inst_len_q, inst_len_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        mem_fire;
  logic [1:0]  new_len;

  // Instruction length from the 6502 opcode grid: cc = op[1:0], bbb = op[4:2].
  function automatic logic [1:0] calc_len(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] bbb;
    logic [1:0] len;
    cc  = op[1:0];
    bbb = op[4:2];
    len = 2'd1;
    if (cc == 2'b01) begin
      if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
      else len = 2'd2;
    end else if (cc != 2'b11) begin
      case (bbb)
        3'b000: begin
          if (op == 8'h20) len = 2'd3;
          else if (op[7]) len = 2'd2;
          else len = 2'd1;
        end
        3'b001, 3'b101: len = 2'd2;
        3'b011, 3'b111: len = 2'd3;
        3'b100: len = (cc == 2'b00) ? 2'd2 : 2'd1;
        default: len = 2'd1;
      endcase
    end
    return len;
  endfunction

  // Read request comes from registered state only; rst_n gating keeps it low during reset.
  assign mem_rd   = rst_n && (state_q != HOLD);
  assign mem_addr = (state_q == VEC_LO) ? RESET_VEC :
                    (state_q == VEC_HI) ? RESET_VEC + 16'd1 : pc_q;
  assign mem_fire = mem_rd && mem_ready;
  assign new_len  = calc_len(mem_rdata);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    inst_opcode_d = inst_opcode_q;
    inst_op1_d    = inst_op1_q;
    inst_op2_d    = inst_op2_q;
    inst_len_d    = inst_len_q;
    inst_pc_d     = inst_pc_q;
    case (state_q)
      VEC_LO: if (mem_fire) begin
        pc_d[7:0] = mem_rdata;
        state_d   = VEC_HI;
      end
      VEC_HI: if (mem_fire) begin
        pc_d[15:8] = mem_rdata;
        state_d    = OPC;
      end
      OPC: if (mem_fire) begin
        inst_opcode_d = mem_rdata;
        inst_pc_d     = pc_q;
        pc_d          = pc_q + 16'd1;
        inst_op1_d    = 8'h00;
        inst_op2_d    = 8'h00;
        inst_len_d    = new_len;
        if (new_len == 2'd1) begin
          state_d      = HOLD;
          inst_valid_d = 1'b1;
        end else begin
          state_d = OP1;
        end
      end
      OP1: if (mem_fire) begin
        inst_op1_d = mem_rdata;
        pc_d       = pc_q + 16'd1;
        if (inst_len_q == 2'd2) begin
          state_d      = HOLD;
          inst_valid_d = 1'b1;
        end else begin
          state_d = OP2;
        end
      end
      OP2: if (mem_fire) begin
        inst_op2_d   = mem_rdata;
        pc_d         = pc_q + 16'd1;
        state_d      = HOLD;
        inst_valid_d = 1'b1;
      end
      HOLD: if (inst_ready) begin
        inst_valid_d = 1'b0;
        state_d      = OPC;
      end
      default: state_d = VEC_LO;
    endcase
    // A redirect overrides any read completing on the same edge; the vector load cannot be redirected.
    if (pc_load && state_q != VEC_LO && state_q != VEC_HI) begin
      pc_d          = pc_load_addr;
      state_d       = OPC;
      inst_valid_d  = 1'b0;
      inst_opcode_d = (state_q == OPC) ? inst_opcode_q : inst_opcode_d;
      inst_op1_d    = (state_q == OP1) ? inst_op1_q : inst_op1_d;
      inst_op2_d    = (state_q == OP2) ? inst_op2_q : inst_op2_d;
      inst_len_d    = (state_q == OPC) ? inst_len_q : inst_len_d;
      inst_pc_d     = (state_q == OPC) ? inst_pc_q : inst_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= VEC_LO;
      pc_q          <= 16'h0000;
      inst_valid_q  <= 1'b0;
      inst_opcode_q <= 8'h00;
      inst_op1_q    <= 8'h00;
      inst_op2_q    <= 8'h00;
      inst_len_q    <= 2'd1;
      inst_pc_q     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_opcode_q <= inst_opcode_d;
      inst_op1_q    <= inst_op1_d;
      inst_op2_q    <= inst_op2_d;
      inst_len_q    <= inst_len_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  assign inst_valid  = inst_valid_q;
  assign inst_opcode = inst_opcode_q;
  assign inst_op1    = inst_op1_q;
  assign inst_op2    = inst_op2_q;
  assign inst_len    = inst_len_q;
  assign inst_pc     = inst_pc_q;

endmodule
